// File: rtl/exe_mem_req_if.sv
// Data-SRAM request/response channel between the EXE request unit and memory.
// The EXE unit is the master; the SRAM side (or a bench model) is the slave.
interface exe_mem_req_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok
  );
endinterface

// File: rtl/exe_mem_req.sv
// EXE-stage data-memory request unit: issues loads/stores, flags misalignment,
// counts in-flight requests and hides responses that belong to flushed work.
module exe_mem_req #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                es_valid,
  input  logic                es_mem_re,
  input  logic                es_mem_we,
  input  logic [1:0]          es_size,
  input  logic [31:0]         es_addr,
  input  logic [31:0]         es_st_data,
  input  logic                es_has_ex,
  input  logic                ms_block,
  input  logic                ms_allowin,
  input  logic                flush,
  output logic                es_ready_go,
  output logic                es_ale,
  output logic                es_mem_issued,
  exe_mem_req_if.master       dsram,
  output logic                ms_data_ok
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACC  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;

  logic memOp;
  logic misaligned;
  logic aleRaw;
  logic canIssue;
  logic reqInt;
  logic accept;

  always_comb begin
    memOp = es_valid & (es_mem_re | es_mem_we);
    case (es_size)
      2'b01:   misaligned = es_addr[0];
      2'b10:   misaligned = (es_addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    aleRaw   = memOp & misaligned;
    // Older flushed responses must drain before a younger request may go out.
    canIssue = memOp & ~es_has_ex & ~aleRaw & ~ms_block & ~flush
             & (discard_q == '0)
             & (outstanding_q < CNT_W'(MAX_OUTSTANDING));
    reqInt   = ~reset & (state_q == IDLE) & canIssue;
    accept   = reqInt & dsram.addr_ok;
  end

  always_comb begin
    dsram.req   = reqInt;
    dsram.wr    = es_mem_we;
    dsram.size  = es_size;
    dsram.addr  = es_addr;
    case (es_size)
      2'b00: begin
        dsram.wstrb = 4'b0001 << es_addr[1:0];
        dsram.wdata = {4{es_st_data[7:0]}};
      end
      2'b01: begin
        dsram.wstrb = es_addr[1] ? 4'b1100 : 4'b0011;
        dsram.wdata = {2{es_st_data[15:0]}};
      end
      default: begin
        dsram.wstrb = 4'b1111;
        dsram.wdata = es_st_data;
      end
    endcase
    if (!es_mem_we) begin
      dsram.wstrb = 4'b0000;
    end
  end

  always_comb begin
    es_ale        = ~reset & aleRaw;
    es_ready_go   = ~memOp | es_has_ex | aleRaw | flush | (state_q == ACC) | accept;
    es_mem_issued = ~reset & ((state_q == ACC) | accept);
    ms_data_ok    = ~reset & dsram.data_ok & (discard_q == '0);
  end

  always_comb begin
    outstanding_d = outstanding_q
                  + {{(CNT_W-1){1'b0}}, accept}
                  - {{(CNT_W-1){1'b0}}, dsram.data_ok};
    discard_d = discard_q;
    state_d   = state_q;
    // A flush turns every in-flight response into one to be discarded.
    if (flush) begin
      discard_d = outstanding_d;
      state_d   = IDLE;
    end else begin
      if ((discard_q != '0) && dsram.data_ok) begin
        discard_d = discard_q - 1'b1;
      end
      case (state_q)
        IDLE:    if (accept && !ms_allowin) state_d = ACC;
        ACC:     if (ms_allowin) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

endmodule
